// File: rtl/alu_nbit_seq.sv
// Registered WIDTH-bit ALU with valid/ready handshakes: single-cycle logic/arith/compare ops
// plus a multi-cycle shift-and-add multiply.
module alu_nbit_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic [2:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             carry,
    output logic             ovf
);

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b011;
    localparam logic [2:0] OP_SLT = 3'b100;
    localparam logic [2:0] OP_MUL = 3'b101;
    localparam logic [2:0] OP_XOR = 3'b110;
    localparam logic [2:0] OP_NOR = 3'b111;

    localparam int unsigned CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH);

    typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

    state_t             state, state_next;
    logic               accept;
    logic [WIDTH-1:0]   b_eff;
    logic               cin_eff;
    logic [WIDTH:0]     sum;
    logic               add_ovf;
    logic [WIDTH-1:0]   alu_res;
    logic               alu_carry;
    logic               alu_ovf;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;
    logic [CW-1:0]      cnt;

    // SUB and SLT share the adder as a + ~b + 1; SLT takes sign XOR overflow.
    always_comb begin
        b_eff     = b;
        cin_eff   = 1'b0;
        alu_res   = '0;
        alu_carry = 1'b0;
        alu_ovf   = 1'b0;
        if (op == OP_SUB || op == OP_SLT) begin
            b_eff   = ~b;
            cin_eff = 1'b1;
        end else if (op == OP_ADD) begin
            cin_eff = cin;
        end
        sum     = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, cin_eff};
        add_ovf = (a[WIDTH-1] == b_eff[WIDTH-1]) & (sum[WIDTH-1] != a[WIDTH-1]);
        case (op)
            OP_AND: alu_res = a & b;
            OP_OR:  alu_res = a | b;
            OP_ADD, OP_SUB: begin
                alu_res   = sum[WIDTH-1:0];
                alu_carry = sum[WIDTH];
                alu_ovf   = add_ovf;
            end
            OP_SLT: alu_res = {{(WIDTH-1){1'b0}}, sum[WIDTH-1] ^ add_ovf};
            OP_XOR: alu_res = a ^ b;
            OP_NOR: alu_res = ~(a | b);
            default: alu_res = '0;
        endcase
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            IDLE: in_ready = 1'b1;
            MUL: begin
                if (cnt == CNT_LAST) state_next = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                in_ready  = out_ready;
                if (out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
        accept = in_valid & in_ready;
        if (accept) state_next = (op == OP_MUL) ? MUL : DONE;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            result <= '0;
            carry  <= 1'b0;
            ovf    <= 1'b0;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            cnt    <= '0;
        end else begin
            state <= state_next;
            if (accept) begin
                if (op == OP_MUL) begin
                    mcand  <= {{WIDTH{1'b0}}, a};
                    mplier <= b;
                    acc    <= '0;
                    cnt    <= '0;
                end else begin
                    result <= alu_res;
                    carry  <= alu_carry;
                    ovf    <= alu_ovf;
                end
            end else if (state == MUL) begin
                // One extra cycle after the last step moves the product into the result.
                if (cnt == CNT_LAST) begin
                    result <= acc[WIDTH-1:0];
                    carry  <= |acc[2*WIDTH-1:WIDTH];
                    ovf    <= 1'b0;
                end else begin
                    if (mplier[0]) acc <= acc + mcand;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + CW'(1);
                end
            end
        end
    end

    assign zero = (result == '0);

endmodule

// File: tb/tb_alu_nbit_seq.sv
// Scoreboard bench for alu_nbit_seq at WIDTH=8: expected results queued at acceptance,
// compared when the result handshake completes.
module tb_alu_nbit_seq;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a, b;
    logic         cin;
    logic [2:0]   op;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         zero, carry, ovf;

    typedef struct {
        logic [W-1:0] res;
        logic         z;
        logic         c;
        logic         v;
        int           lat;
        int           acc_cyc;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;

    alu_nbit_seq #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .op(op), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .zero(zero), .carry(carry), .ovf(ovf)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [2:0] o, input logic [W-1:0] x,
                                   input logic [W-1:0] y, input logic ci);
        exp_t   e;
        int     sx, sy, d;
        logic [W:0]     s9;
        logic [2*W-1:0] p;
        sx = $signed(x);
        sy = $signed(y);
        e.c = 1'b0; e.v = 1'b0; e.lat = 0; e.res = '0; e.acc_cyc = 0;
        case (o)
            3'b000: e.res = x & y;
            3'b001: e.res = x | y;
            3'b010: begin
                s9 = x + y + ci;
                e.res = s9[W-1:0];
                e.c = s9[W];
                d = sx + sy + int'(ci);
                e.v = (d > 127) || (d < -128);
            end
            3'b011: begin
                e.res = x - y;
                e.c = (x >= y);
                d = sx - sy;
                e.v = (d > 127) || (d < -128);
            end
            3'b100: e.res = (sx < sy) ? 8'd1 : 8'd0;
            3'b101: begin
                p = x * y;
                e.res = p[W-1:0];
                e.c = (p[2*W-1:W] != 0);
                e.lat = W + 1;
            end
            3'b110: e.res = x ^ y;
            default: e.res = ~(x | y);
        endcase
        e.z = (e.res == 0);
        return e;
    endfunction

    task automatic issue(input logic [2:0] o, input logic [W-1:0] x,
                         input logic [W-1:0] y, input logic ci);
        exp_t e;
        int n = 0;
        in_valid = 1'b1; op = o; a = x; b = y; cin = ci;
        #1;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) check("accept_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a = W'($urandom); b = W'($urandom); cin = 1'($urandom); op = 3'($urandom);
        e = model(o, x, y, ci);
        e.acc_cyc = cyc;
        sb.push_back(e);
    endtask

    task automatic collect(input string tag, input bit chk_lat);
        exp_t e;
        int   n = 0;
        bit   busy_rdy = 1'b0;
        @(negedge clk);
        while (!out_valid && n < 100) begin
            if (in_ready) busy_rdy = 1'b1;
            @(negedge clk);
            n++;
        end
        if (!out_valid) begin
            check({tag, "_timeout"}, 32'd0, 32'd1);
        end else if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            check({tag, "_result"}, 32'(result), 32'(e.res));
            check({tag, "_zero"},   32'(zero),   32'(e.z));
            check({tag, "_carry"},  32'(carry),  32'(e.c));
            check({tag, "_ovf"},    32'(ovf),    32'(e.v));
            check({tag, "_busy_in_ready"}, 32'(busy_rdy), 32'd0);
            if (chk_lat) check({tag, "_latency"}, 32'(cyc - e.acc_cyc), 32'(e.lat));
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        exp_t e;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; cin = 1'b0; op = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_result",    32'(result),    32'd0);
        check("rst_zero",      32'(zero),      32'd1);
        check("rst_carry",     32'(carry),     32'd0);
        check("rst_ovf",       32'(ovf),       32'd0);
        check("rst_in_ready",  32'(in_ready),  32'd1);
        rst_n = 1'b1;

        issue(3'b010, 8'hFF, 8'h01, 1'b0); collect("add_wrap", 1'b1);
        issue(3'b010, 8'hFF, 8'h01, 1'b1); collect("add_cin", 1'b1);
        issue(3'b010, 8'h7F, 8'h01, 1'b0); collect("add_ovf", 1'b1);
        issue(3'b011, 8'h80, 8'h01, 1'b1); collect("sub_ovf", 1'b1);
        issue(3'b011, 8'h01, 8'h02, 1'b0); collect("sub_borrow", 1'b1);
        issue(3'b100, 8'hFF, 8'h01, 1'b0); collect("slt_neg", 1'b1);
        issue(3'b100, 8'h01, 8'hFF, 1'b0); collect("slt_pos", 1'b1);
        issue(3'b100, 8'h80, 8'h7F, 1'b0); collect("slt_ovf", 1'b1);
        issue(3'b000, 8'hF0, 8'h3C, 1'b1); collect("and", 1'b1);
        issue(3'b001, 8'hF0, 8'h3C, 1'b1); collect("or", 1'b1);
        issue(3'b110, 8'hF0, 8'h3C, 1'b1); collect("xor", 1'b1);
        issue(3'b111, 8'hF0, 8'h3C, 1'b1); collect("nor", 1'b1);
        issue(3'b101, 8'h0F, 8'h11, 1'b0); collect("mul_ff", 1'b1);
        issue(3'b101, 8'h10, 8'h10, 1'b0); collect("mul_ovf", 1'b1);
        issue(3'b101, 8'hFF, 8'hFF, 1'b0); collect("mul_max", 1'b1);

        for (int i = 0; i < 20; i++) begin
            issue(3'($urandom), W'($urandom), W'($urandom), 1'($urandom));
            collect("rand", 1'b1);
        end

        // Backpressure: result must hold while out_ready is low.
        out_ready = 1'b0;
        issue(3'b010, 8'h80, 8'h80, 1'b1);
        e = sb[0];
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_out_valid", 32'(out_valid), 32'd1);
            check("bp_result",    32'(result),    32'(e.res));
            check("bp_carry",     32'(carry),     32'(e.c));
            check("bp_ovf",       32'(ovf),       32'(e.v));
            check("bp_zero",      32'(zero),      32'(e.z));
            check("bp_in_ready",  32'(in_ready),  32'd0);
        end
        out_ready = 1'b1;
        void'(sb.pop_front());
        issue(3'b001, 8'h12, 8'h21, 1'b0);
        collect("bp_or", 1'b1);

        // Reset during the fourth multiply step discards the pending product.
        issue(3'b101, 8'h0F, 8'h11, 1'b0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        void'(sb.pop_front());
        @(negedge clk);
        check("mrst_out_valid", 32'(out_valid), 32'd0);
        check("mrst_result",    32'(result),    32'd0);
        check("mrst_zero",      32'(zero),      32'd1);
        check("mrst_carry",     32'(carry),     32'd0);
        check("mrst_in_ready",  32'(in_ready),  32'd1);
        issue(3'b010, 8'h12, 8'h34, 1'b1); collect("post_rst_add", 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
